alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command front-end that sits directly upstream of the combinational alu. It accepts one operation per valid/ready handshake and registers the operands into the alu. It then captures the alu result and flags into a response register and returns them on a second valid/ready handshake. It also keeps a persistent carry/borrow flag so that multi-word ADD/SUB chains run without software recomputing cin.

Parameters:
WIDTH, 4, datapath width; must match the alu instance parameter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_opcode  in  4  alu_ops opcode
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_use_carry  in  1  1: alu_cin = carry_flag; 0: alu_cin = 0
clear_carry  in  1  synchronous clear of carry_flag
alu_opcode  out  4  to alu opcode
alu_a  out  WIDTH  to alu a
alu_b  out  WIDTH  to alu b
alu_cin  out  1  to alu cin
alu_y  in  WIDTH  from alu y
alu_cout  in  1  from alu cout (ADD: carry out; SUB: borrow out)
alu_overflow  in  1  from alu overflow
alu_negative  in  1  from alu negative
alu_zero  in  1  from alu zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_y  out  WIDTH  captured result
rsp_flags  out  4  {N,Z,C,V} after this op
rsp_err  out  1  opcode was not a legal alu_ops code
carry_flag  out  1  persistent C register

Behaviour:
- Interface: one clock (clk), reset synchronous and active-high (reset). All state updates occur on the rising edge of clk.
- Reset values:
  - state = IDLE, cmd_ready = 1, rsp_valid = 0.
  - rsp_y = 0, rsp_flags = 0, rsp_err = 0, carry_flag = 0.
  - alu_opcode/alu_a/alu_b/alu_cin registers = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_opcode, cmd_a and cmd_b into the alu_* registers.
  - alu_cin register <= cmd_use_carry ? carry_flag : 0, sampled in the same cycle, before any clear_carry that cycle takes effect.
  - Next state is EXEC if the opcode is legal.
  - If the opcode is illegal (any value other than the ten alu_ops codes LL/LR/AL/AR_SHIFT, NOT, AND, OR, XOR, ADD, SUB):
    - rsp_err <= 1, rsp_y <= 0.
    - rsp_flags <= {0, 0, carry_flag, 0}.
    - Next state is RESP and EXEC is skipped.
- EXEC (one cycle; the alu is combinational and its outputs are stable):
  - rsp_y <= alu_y, rsp_err <= 0.
  - N and Z are always taken from alu_negative and alu_zero.
  - ADD/SUB: C = alu_cout, V = alu_overflow, and carry_flag <= alu_cout.
  - All other ops: C = current carry_flag, V = 0, and carry_flag is unchanged.
  - Next state is RESP.
- RESP:
  - rsp_valid = 1; rsp_y, rsp_flags and rsp_err stay stable until accepted.
  - On rsp_ready, go to IDLE.
  - cmd_ready = 0 in both EXEC and RESP.
- Latency and throughput:
  - A command accepted in cycle T has rsp_valid asserted in cycle T+2, or T+1 for an illegal opcode.
  - Best-case throughput is one op per 3 cycles.
- clear_carry:
  - Takes effect in any state.
  - It has priority over an EXEC update in the same cycle: carry_flag becomes 0, while rsp_flags.C still reports alu_cout.
- alu_* outputs hold their last values outside EXEC. The alu output is only sampled in EXEC.
- Reset mid-operation (EXEC or RESP): the command is dropped, rsp_valid deasserts the next cycle, and all registers return to their reset values.
- Widths: no internal arithmetic. Operands pass through unmodified at WIDTH bits.

Test Plan:
1. Legal ADD, WIDTH=4, with a real alu #(4) attached:
   - Stimulus: cmd ADD a=0100 b=0110 use_carry=0, rsp_ready=1.
   - Response: cmd_ready low for 2 cycles; rsp_valid at T+2; rsp_y=1010; flags N=1 Z=0 C=0 V=1; carry_flag=0.
2. Carry chain:
   - ADD 1100+0110 use_carry=0 -> rsp_y=0010, C=1, carry_flag=1.
   - Then ADD 0001+0000 use_carry=1 -> alu_cin=1, rsp_y=0010, C=0, carry_flag=0.
3. SUB borrow:
   - SUB 0011-0101 -> rsp_y=1110, C=1, carry_flag=1.
   - Then AND 1111&0101 -> rsp_y=0101, C=1 (held), V=0, carry_flag still 1.
4. Backpressure and illegal opcode:
   - Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y/rsp_flags stable, cmd_ready=0 throughout.
   - An illegal opcode (4'hF if unused in alu_ops) -> rsp_valid at T+1, rsp_err=1, rsp_y=0.
5. clear_carry collision:
   - With carry_flag=0, ADD 1000+1000 with clear_carry=1 in the EXEC cycle -> rsp_flags.C=1, carry_flag=0 the following cycle.
6. Reset mid-op:
   - Assert reset during RESP -> next cycle rsp_valid=0, cmd_ready=1, carry_flag=0, rsp_y=0, rsp_flags=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/response front-end for the combinational alu with persistent carry
module alu_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_carry,
    input  logic             clear_carry,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             carry_flag
);

    // alu_ops encoding: shifts 0-3, NOT 4, AND 5, OR 6, XOR 7, ADD 8, SUB 9
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_LAST = OP_SUB;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic   cmd_legal;
    logic   exec_arith;

    assign cmd_legal  = (cmd_opcode <= OP_LAST);
    assign exec_arith = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = cmd_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            rsp_y      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                alu_opcode <= cmd_opcode;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                // carry_flag here is the pre-clear value of this cycle
                alu_cin    <= cmd_use_carry & carry_flag;
                if (!cmd_legal) begin
                    rsp_y     <= '0;
                    rsp_flags <= {2'b00, carry_flag, 1'b0};
                    rsp_err   <= 1'b1;
                end
            end
            if (state == EXEC) begin
                rsp_y     <= alu_y;
                rsp_err   <= 1'b0;
                rsp_flags <= {alu_negative, alu_zero,
                              exec_arith ? alu_cout : carry_flag,
                              exec_arith & alu_overflow};
            end
        end
    end

    // clear_carry wins over an EXEC update; rsp_flags.C still reports alu_cout
    always_ff @(posedge clk) begin
        if (reset || clear_carry) begin
            carry_flag <= 1'b0;
        end else if (state == EXEC && exec_arith) begin
            carry_flag <= alu_cout;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a reference alu
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_use_carry;
    logic       clear_carry;
    logic [3:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_y;
    logic       alu_cout;
    logic       alu_overflow;
    logic       alu_negative;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_y;
    logic [3:0] rsp_flags;
    logic       rsp_err;
    logic       carry_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_carry(cmd_use_carry),
        .clear_carry(clear_carry),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .carry_flag(carry_flag)
    );

    // Reference alu: shifts by one, SUB cout is borrow
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        alu_y        = '0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_opcode)
            4'd0: alu_y = alu_a << 1;
            4'd1: alu_y = alu_a >> 1;
            4'd2: alu_y = alu_a << 1;
            4'd3: alu_y = {alu_a[3], alu_a[3:1]};
            4'd4: alu_y = ~alu_a;
            4'd5: alu_y = alu_a & alu_b;
            4'd6: alu_y = alu_a | alu_b;
            4'd7: alu_y = alu_a ^ alu_b;
            4'd8: begin
                alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                alu_y        = alu_sum[3:0];
                alu_cout     = alu_sum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
            end
            4'd9: begin
                alu_sum      = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
                alu_y        = alu_sum[3:0];
                alu_cout     = alu_sum[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (alu_y[3] != alu_a[3]);
            end
            default: alu_y = '0;
        endcase
    end
    assign alu_zero     = (alu_y == 4'd0);
    assign alu_negative = alu_y[3];

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       uc;
        logic [3:0] y;
        logic [3:0] flags;
        logic       err;
        logic       carry;
        int         lat;
        logic       bp;
    } vec_t;

    typedef struct {
        logic [3:0] y;
        logic [3:0] flags;
        logic       err;
        logic       carry;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%0h expected=none t=%0t", rsp_y, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_y", rsp_y, e.y);
                check("rsp_flags", rsp_flags, e.flags);
                check("rsp_err", rsp_err, e.err);
                check("carry_flag", carry_flag, e.carry);
            end
        end
    end

    task automatic send(input vec_t v, input logic clr);
        int  lat;
        bit  seen;
        @(negedge clk);
        cmd_opcode    = v.op;
        cmd_a         = v.a;
        cmd_b         = v.b;
        cmd_use_carry = v.uc;
        cmd_valid     = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        sbq.push_back('{v.y, v.flags, v.err, v.carry});
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        clear_carry = clr;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (i >= 2) clear_carry = 1'b0;
            if (rsp_valid) begin
                seen = 1;
                lat  = i;
            end else begin
                check("cmd_ready_busy", cmd_ready, 0);
            end
        end
        clear_carry = 1'b0;
        check("latency", lat, v.lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t vclr;
        vec_t vrst;
        //            op     a      b      uc    y      flags    err   carry lat bp
        vecs[0]  = '{4'd8, 4'h4, 4'h6, 1'b0, 4'hA, 4'b1001, 1'b0, 1'b0, 2, 1'b0};
        vecs[1]  = '{4'd8, 4'hC, 4'h6, 1'b0, 4'h2, 4'b0010, 1'b0, 1'b1, 2, 1'b0};
        vecs[2]  = '{4'd8, 4'h1, 4'h0, 1'b1, 4'h2, 4'b0000, 1'b0, 1'b0, 2, 1'b0};
        vecs[3]  = '{4'd9, 4'h3, 4'h5, 1'b0, 4'hE, 4'b1010, 1'b0, 1'b1, 2, 1'b0};
        vecs[4]  = '{4'd5, 4'hF, 4'h5, 1'b0, 4'h5, 4'b0010, 1'b0, 1'b1, 2, 1'b1};
        vecs[5]  = '{4'd7, 4'h5, 4'h5, 1'b0, 4'h0, 4'b0110, 1'b0, 1'b1, 2, 1'b0};
        vecs[6]  = '{4'hF, 4'h3, 4'h3, 1'b0, 4'h0, 4'b0010, 1'b1, 1'b1, 1, 1'b0};
        vecs[7]  = '{4'd4, 4'h0, 4'h0, 1'b0, 4'hF, 4'b1010, 1'b0, 1'b1, 2, 1'b0};
        vecs[8]  = '{4'd8, 4'h7, 4'h1, 1'b1, 4'h9, 4'b1001, 1'b0, 1'b0, 2, 1'b0};
        vecs[9]  = '{4'd9, 4'h0, 4'h1, 1'b1, 4'hF, 4'b1010, 1'b0, 1'b1, 2, 1'b0};
        vecs[10] = '{4'd0, 4'h3, 4'h0, 1'b0, 4'h6, 4'b0010, 1'b0, 1'b1, 2, 1'b0};
        vecs[11] = '{4'd3, 4'h8, 4'h0, 1'b0, 4'hC, 4'b1010, 1'b0, 1'b1, 2, 1'b0};
        vclr     = '{4'd8, 4'h8, 4'h8, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b0, 2, 1'b0};
        vrst     = '{4'd8, 4'hC, 4'h6, 1'b0, 4'h2, 4'b0010, 1'b0, 1'b1, 2, 1'b0};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_use_carry = 1'b0;
        clear_carry = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_regs", {alu_opcode, alu_a, alu_b, 3'b000, alu_cin}, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].bp) rsp_ready = 1'b0;
            send(vecs[i], 1'b0);
            if (vecs[i].bp) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_rsp_valid", rsp_valid, 1);
                    check("bp_rsp_y", rsp_y, vecs[i].y);
                    check("bp_rsp_flags", rsp_flags, vecs[i].flags);
                    check("bp_cmd_ready", cmd_ready, 0);
                end
                rsp_ready = 1'b1;
            end
            drain();
            if (i == 2) check("alu_cin_chain", alu_cin, 1);
        end

        @(negedge clk);
        clear_carry = 1'b1;
        @(negedge clk);
        clear_carry = 1'b0;
        check("clear_idle", carry_flag, 0);

        send(vclr, 1'b1);
        drain();

        rsp_ready = 1'b0;
        send(vrst, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_carry", carry_flag, 0);
        check("midrst_rsp_y", rsp_y, 0);
        check("midrst_rsp_flags", rsp_flags, 0);
        reset = 1'b0;
        sbq.delete();
        rsp_ready = 1'b1;

        send(vecs[0], 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
